// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between the filter pipeline (port 0) and the control core (port 1).
// Optional macro ALU_MUL_MULTICYCLE_EN adds a MULW hold state so opcode 3'b010 can use a multicycle path.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; the granted port sees ready combinationally
// EXEC  | latched operands and opcode are driven to the ALU for one cycle
// MULW  | multiply settle: operands held, down-counter runs to 0 (macro only)
// RESP  | result held on resp_* until the owning port takes it
module alu_arbiter #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [2:0]        resp_flags,
    output logic              resp_err,
    output logic              busy,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MULW = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_MAX    = 3'b100;
    localparam logic [2:0] CTRL_IDLE = 3'b111;

    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_mul_cycles_range
        $error("alu_arbiter: MUL_CYCLES must be in 1..15");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_last_grant;
    logic              r_gnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_flags;
    logic              r_err;

    logic              w_any_req;
    logic              w_sel;
    logic              w_take;
    logic              w_to_mulw;
    logic              w_capture;
    logic              w_owner_ready;
    logic              w_resp_done;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        w_any_req = req0_valid | req1_valid;
        w_sel     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
        w_take    = (r_state == S_IDLE) & w_any_req & rst_n;
    end

    assign req0_ready = w_take & ~w_sel;
    assign req1_ready = w_take &  w_sel;

    assign w_owner_ready = r_gnt ? resp1_ready : resp0_ready;
    assign w_resp_done   = (r_state == S_RESP) & w_owner_ready;

`ifdef ALU_MUL_MULTICYCLE_EN
    logic [3:0] r_cnt;

    assign w_to_mulw = (r_state == S_EXEC) && (r_op == OP_MUL);
    assign w_capture = ((r_state == S_EXEC) && !w_to_mulw) ||
                       ((r_state == S_MULW) && (r_cnt == 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_to_mulw) begin
            r_cnt <= 4'(MUL_CYCLES - 1);
        end else if ((r_state == S_MULW) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end
`else
    assign w_to_mulw = 1'b0;
    assign w_capture = (r_state == S_EXEC);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_to_mulw ? S_MULW : S_RESP;
            S_MULW:  if (w_capture) w_state_nxt = S_RESP;
            S_RESP:  if (w_resp_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // last_grant resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= CTRL_IDLE;
        end else if (w_take) begin
            r_last_grant <= w_sel;
            r_gnt        <= w_sel;
            r_a          <= w_sel ? req1_a  : req0_a;
            r_b          <= w_sel ? req1_b  : req0_b;
            r_op         <= w_sel ? req1_op : req0_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_flags <= 3'b000;
            r_err   <= 1'b0;
        end else if (w_capture) begin
            r_data  <= alu_out;
            r_flags <= {alu_c, alu_z, alu_n};
            r_err   <= (r_op > OP_MAX);
        end
    end

    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_ctrl = ((r_state == S_EXEC) || (r_state == S_MULW)) ? r_op : CTRL_IDLE;

    assign resp0_valid = (r_state == S_RESP) & ~r_gnt;
    assign resp1_valid = (r_state == S_RESP) &  r_gnt;
    assign resp_data   = r_data;
    assign resp_flags  = r_flags;
    assign resp_err    = r_err;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and reference model; honours ALU_MUL_MULTICYCLE_EN.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int MC = 3;
`ifdef ALU_MUL_MULTICYCLE_EN
    localparam bit MULEN = 1'b1;
`else
    localparam bit MULEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [DW-1:0] resp_data;
    logic [2:0]    resp_flags;
    logic          resp_err, busy;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [2:0]    alu_ctrl;
    logic          alu_c, alu_z, alu_n;
    logic [34:0]   alu_res;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_flags(resp_flags), .resp_err(resp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n)
    );

    // Returns {C, Z, N, out}; also serves as the external ALU.
    function automatic logic [34:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        w = '0;
        case (op)
            3'd0: w = {1'b0, a} + {1'b0, b};
            3'd1: w = {1'b0, a} - {1'b0, b};
            3'd2: w = {1'b0, a * b};
            3'd3: w = {1'b0, a & b};
            3'd4: w = {1'b0, a | b};
            default: w = '0;
        endcase
        return {w[32], (w[31:0] == 32'd0), w[31], w[31:0]};
    endfunction

    always_comb alu_res = ref_alu(alu_ctrl, alu_a, alu_b);
    assign alu_out = alu_res[31:0];
    assign alu_c   = alu_res[34];
    assign alu_z   = alu_res[33];
    assign alu_n   = alu_res[32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (p == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic start(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(negedge clk);
        drive(p, 1'b1, a, b, op);
        #1;
        chk("req_ready_owner", (p == 0) ? req0_ready : req1_ready, 1'b1);
        chk("req_ready_other", (p == 0) ? req1_ready : req0_ready, 1'b0);
        @(posedge clk);
        #1;
        drive(p, 1'b0, a, b, op);
    endtask

    // Called just after the handshake edge; finishes with the owner's response taken.
    task automatic await_resp(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                              input logic [31:0] ed, input logic [2:0] ef, input logic ee, input int hold);
        int n, drive_ok, rdy_leak, explat;
        logic v;
        n = 0; drive_ok = 0; rdy_leak = 0;
        explat = (MULEN && op == 3'b010) ? 2 + MC : 2;
        if (p == 0) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        do begin
            @(negedge clk);
            #1;
            n++;
            v = (p == 0) ? resp0_valid : resp1_valid;
            if (!v) begin
                if (alu_ctrl === op && alu_a === a && alu_b === b) drive_ok++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0) rdy_leak++;
            end
        end while (!v && n < 40);
        chk("latency", n, explat);
        chk("alu_drive_cycles", drive_ok, explat - 1);
        chk("req_ready_quiet", rdy_leak, 0);
        chk("resp_valid_owner", v, 1'b1);
        chk("resp_valid_other", (p == 0) ? resp1_valid : resp0_valid, 1'b0);
        chk("resp_data", resp_data, ed);
        chk("resp_flags", resp_flags, ef);
        chk("resp_err", resp_err, ee);
        chk("busy_resp", busy, 1'b1);
        chk("alu_ctrl_resp", alu_ctrl, 3'b111);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", (p == 0) ? resp0_valid : resp1_valid, 1'b1);
            chk("hold_data", resp_data, ed);
            chk("hold_flags", resp_flags, ef);
            chk("hold_req_ready", {req0_ready, req1_ready}, 2'b00);
        end
        if (p == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        chk("resp_valid_drop", {resp0_valid, resp1_valid}, 2'b00);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, {req0_ready, req1_ready}, 2'b00);
        chk({tag, "_valid"}, {resp0_valid, resp1_valid}, 2'b00);
        chk({tag, "_data"}, resp_data, 32'd0);
        chk({tag, "_flags_err_busy"}, {resp_flags, resp_err, busy}, 5'd0);
        chk({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 3'b111);
    endtask

    initial begin
        logic [31:0] ops_a[2][4];
        logic [31:0] ops_b[2][4];
        logic [2:0]  ops_op[2][4];
        logic [34:0] r;
        int idx[2];
        int p, expect_p;
        logic [31:0] a, b;
        logic [2:0]  op;

        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_op = 0; req1_op = 0; resp0_ready = 0; resp1_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations from the plan.
        start(0, 32'd5, 32'd7, 3'd0);
        await_resp(0, 32'd5, 32'd7, 3'd0, 32'd12, 3'b000, 1'b0, 0);
        start(1, 32'd3, 32'd3, 3'd1);
        await_resp(1, 32'd3, 32'd3, 3'd1, 32'd0, 3'b010, 1'b0, 0);
        start(1, 32'd0, 32'd1, 3'd1);
        await_resp(1, 32'd0, 32'd1, 3'd1, 32'hFFFF_FFFF, 3'b101, 1'b0, 0);
        start(0, 32'd6, 32'd7, 3'd2);
        await_resp(0, 32'd6, 32'd7, 3'd2, 32'd42, 3'b000, 1'b0, 0);
        start(1, 32'h1234, 32'h5678, 3'b110);
        await_resp(1, 32'h1234, 32'h5678, 3'b110, 32'd0, 3'b010, 1'b1, 0);

        // Both ports valid throughout: grants alternate starting at port 0; first response held 5 cycles.
        for (int q = 0; q < 2; q++)
            for (int k = 0; k < 4; k++) begin
                ops_a[q][k]  = $urandom;
                ops_b[q][k]  = $urandom;
                ops_op[q][k] = 3'($urandom_range(0, 4));
            end
        idx[0] = 0; idx[1] = 0; expect_p = 0;
        @(negedge clk);
        drive(0, 1'b1, ops_a[0][0], ops_b[0][0], ops_op[0][0]);
        drive(1, 1'b1, ops_a[1][0], ops_b[1][0], ops_op[1][0]);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("alt_ready0", req0_ready, (expect_p == 0));
            chk("alt_ready1", req1_ready, (expect_p == 1));
            p = expect_p;
            a = ops_a[p][idx[p]]; b = ops_b[p][idx[p]]; op = ops_op[p][idx[p]];
            @(posedge clk);
            #1;
            idx[p]++;
            if (idx[p] < 4) drive(p, 1'b1, ops_a[p][idx[p]], ops_b[p][idx[p]], ops_op[p][idx[p]]);
            else            drive(p, 1'b0, 32'd0, 32'd0, 3'd0);
            r = ref_alu(op, a, b);
            await_resp(p, a, b, op, r[31:0], r[34:32], (op > 3'd4), (k == 0) ? 5 : 0);
            expect_p = 1 - expect_p;
        end
        drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 32'd0, 32'd0, 3'd0);

        // Reset during EXEC discards the operation and restores the port-0 tie preference.
        start(0, 32'd9, 32'd9, 3'd0);
        @(negedge clk);
        #1;
        chk("exec_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_reset_quiet", {resp0_valid, resp1_valid, busy}, 3'b000);
        end
        @(negedge clk);
        drive(0, 1'b1, 32'd100, 32'd23, 3'd0);
        drive(1, 1'b1, 32'd1, 32'd1, 3'd1);
        #1;
        chk("reset_tie_port0", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
        await_resp(0, 32'd100, 32'd23, 3'd0, 32'd123, 3'b000, 1'b0, 0);

        // Randomized single-port operations against the reference model.
        for (int k = 0; k < 24; k++) begin
            p  = $urandom_range(0, 1);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = 3'($urandom_range(0, 7));
            r  = ref_alu(op, a, b);
            start(p, a, b, op);
            await_resp(p, a, b, op, r[31:0], r[34:32], (op > 3'd4), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
